fetch_sequencer: RTL and testbench

Control block for the instruction-fetch stage. Owns the program-counter register and sequences it: start-up, sequential advance, stall hold, branch/jump redirect with IF/ID flush, and halt. It presents a valid/ready fetch handshake to the instruction-memory / IF-ID side. It replaces the free-running PC update with an explicitly sequenced one.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_sequencer_pc_reg.sv | 37 +++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default geometry and the redirect-target alignment check.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam int          DEF_ADDR_W   = 8;
  localparam int          DEF_STEP     = 4;
  localparam int          DEF_CNT_W    = 16;
  localparam logic [7:0]  DEF_RESET_PC = 8'd0;
  localparam logic [7:0]  DEF_LAST_PC  = 8'd252;
  localparam logic [1:0]  ALIGN_MASK   = 2'b11;

  // Fetch addresses must be word aligned; only the two low bits matter.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return ((addr_lo & ALIGN_MASK) == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program-counter storage: async reset to the reset PC, loads only when enabled.
module pc_reg #(
  parameter int              W         = 8,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] val_d;
  logic [W-1:0] val_q;

  // Next-value selection: hold unless a load is requested.
  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = d;
    end else begin
      val_d = val_q;
    end
  end

  // PC flop with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= RESET_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and walks it through start-up,
// sequential advance, stall, redirect with IF/ID flush, and halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int                STEP     = DEF_STEP,
  parameter logic [ADDR_W-1:0] LAST_PC  = DEF_LAST_PC,
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic              halted,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              err_d, err_q;
  logic              pc_load_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic [ADDR_W-1:0] pc_s;
  logic              flush_s;

  pc_reg #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load_s),
    .d    (pc_next_s),
    .q    (pc_s)
  );

  // Next-state, PC, counter and error sequencing in RUN priority order.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pc_load_s = 1'b0;
    pc_next_s = pc_s;
    flush_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_RUN;
          pc_load_s = 1'b1;
          pc_next_s = RESET_PC;
          cnt_d     = '0;
          err_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          flush_s = 1'b1;
          if (is_aligned(redirect_target[1:0])) begin
            pc_load_s = 1'b1;
            pc_next_s = redirect_target;
            // The redirected slot is still consumed downstream when accepted.
            if (fetch_ready) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end
        end else if (fetch_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pc_s == LAST_PC) begin
            state_d = ST_HALT;
          end else begin
            pc_load_s = 1'b1;
            pc_next_s = pc_s + ADDR_W'(STEP);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, fetch counter and sticky misalignment flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pc           = pc_s;
  assign fetch_valid  = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALT);
  assign flush        = flush_s;
  assign misalign_err = err_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        fetch_ready;
  logic [7:0]  pc;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int checks;
  int failures;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .halt_req        (halt_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_ready     (fetch_ready),
    .pc              (pc),
    .fetch_valid     (fetch_valid),
    .flush           (flush),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ((pc !== 8'd0) || (fetch_valid !== 1'b0) || (flush !== 1'b0) || (halted !== 1'b0) ||
        (misalign_err !== 1'b0) || (fetch_count !== 16'd0)) begin
      failures++;
      $display("FAIL reset_state: pc=%0d fv=%b fl=%b h=%b err=%b cnt=%0d, need 0 0 0 0 0 0",
               pc, fetch_valid, flush, halted, misalign_err, fetch_count);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ((fetch_valid !== 1'b0) || (pc !== 8'd0)) begin
      failures++;
      $display("FAIL idle_no_start: fv=%b pc=%0d, need fv=0 pc=0", fetch_valid, pc);
    end
  endtask

  task automatic test_sequential();
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_ready = 1'b1;
    checks++;
    if ((pc !== 8'd0) || (fetch_valid !== 1'b1)) begin
      failures++;
      $display("FAIL first_fetch: pc=%0d fv=%b, need pc=0 fv=1", pc, fetch_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (pc !== 8'(4 * i)) begin
        failures++;
        $display("FAIL seq_pc[%0d]: pc=%0d, need %0d", i, pc, 4 * i);
      end
    end
    checks++;
    if (fetch_count !== 16'd4) begin
      failures++;
      $display("FAIL seq_count: cnt=%0d, need 4", fetch_count);
    end
  endtask

  task automatic test_stall();
    // Halt then restart to begin again from pc=0.
    fetch_ready = 1'b0;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_ready = 1'b1;
    step();
    step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ((pc !== 8'd8) || (fetch_count !== 16'd2) || (fetch_valid !== 1'b1)) begin
        failures++;
        $display("FAIL stall_hold[%0d]: pc=%0d cnt=%0d fv=%b, need pc=8 cnt=2 fv=1",
                 i, pc, fetch_count, fetch_valid);
      end
    end
    fetch_ready = 1'b1;
    step();
    checks++;
    if ((pc !== 8'd12) || (fetch_count !== 16'd3)) begin
      failures++;
      $display("FAIL stall_release: pc=%0d cnt=%0d, need pc=12 cnt=3", pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_target = 8'd40;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL redirect_flush: flush=%b, need 1", flush);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ((pc !== 8'd40) || (fetch_valid !== 1'b1) || (flush !== 1'b0) || (fetch_count !== 16'd4)) begin
      failures++;
      $display("FAIL redirect_target: pc=%0d fv=%b fl=%b cnt=%0d, need pc=40 fv=1 fl=0 cnt=4",
               pc, fetch_valid, flush, fetch_count);
    end
    redirect_valid = 1'b1;
    redirect_target = 8'd42;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL misalign_flush: flush=%b, need 1", flush);
    end
    step();
    redirect_valid = 1'b0;
    checks++;
    if ((misalign_err !== 1'b1) || (halted !== 1'b1) || (pc !== 8'd40) ||
        (fetch_valid !== 1'b0) || (fetch_count !== 16'd4)) begin
      failures++;
      $display("FAIL misalign_halt: err=%b h=%b pc=%0d fv=%b cnt=%0d, need 1 1 40 0 4",
               misalign_err, halted, pc, fetch_valid, fetch_count);
    end
    redirect_valid = 1'b1;
    redirect_target = 8'd80;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_halt: flush=%b, need 0", flush);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_last_pc();
    fetch_ready = 1'b0;
    start = 1'b1;
    step();
    checks++;
    if ((pc !== 8'd0) || (fetch_count !== 16'd0) || (misalign_err !== 1'b0) || (halted !== 1'b0)) begin
      failures++;
      $display("FAIL restart_clear: pc=%0d cnt=%0d err=%b h=%b, need 0 0 0 0",
               pc, fetch_count, misalign_err, halted);
    end
    // start held while running must not reload the PC.
    fetch_ready = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ((pc !== 8'd4) || (fetch_count !== 16'd1)) begin
      failures++;
      $display("FAIL start_in_run: pc=%0d cnt=%0d, need pc=4 cnt=1", pc, fetch_count);
    end
    for (int i = 0; i < 62; i++) begin
      step();
    end
    checks++;
    if ((pc !== 8'd252) || (fetch_valid !== 1'b1) || (fetch_count !== 16'd63)) begin
      failures++;
      $display("FAIL reach_last: pc=%0d fv=%b cnt=%0d, need 252 1 63", pc, fetch_valid, fetch_count);
    end
    step();
    checks++;
    if ((pc !== 8'd252) || (fetch_valid !== 1'b0) || (halted !== 1'b1) || (fetch_count !== 16'd64)) begin
      failures++;
      $display("FAIL last_halt: pc=%0d fv=%b h=%b cnt=%0d, need 252 0 1 64",
               pc, fetch_valid, halted, fetch_count);
    end
    step();
    checks++;
    if (pc !== 8'd252) begin
      failures++;
      $display("FAIL no_wrap: pc=%0d, need 252", pc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ((pc !== 8'd0) || (fetch_count !== 16'd0) || (fetch_valid !== 1'b1)) begin
      failures++;
      $display("FAIL last_restart: pc=%0d cnt=%0d fv=%b, need 0 0 1", pc, fetch_count, fetch_valid);
    end
  endtask

  task automatic test_halt_vs_redirect();
    step();
    step();
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 8'd40;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL halt_redirect_flush: flush=%b, need 0", flush);
    end
    step();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if ((halted !== 1'b1) || (pc !== 8'd8) || (fetch_count !== 16'd2)) begin
      failures++;
      $display("FAIL halt_redirect_state: h=%b pc=%0d cnt=%0d, need 1 8 2", halted, pc, fetch_count);
    end
  endtask

  task automatic test_rst_mid_stall();
    start = 1'b1;
    step();
    start = 1'b0;
    fetch_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    fetch_ready = 1'b0;
    step();
    checks++;
    if ((pc !== 8'd20) || (fetch_valid !== 1'b1)) begin
      failures++;
      $display("FAIL pre_rst_stall: pc=%0d fv=%b, need 20 1", pc, fetch_valid);
    end
    redirect_valid = 1'b1;
    redirect_target = 8'd100;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ((pc !== 8'd0) || (fetch_valid !== 1'b0) || (flush !== 1'b0) || (halted !== 1'b0) ||
        (misalign_err !== 1'b0) || (fetch_count !== 16'd0)) begin
      failures++;
      $display("FAIL rst_mid_stall: pc=%0d fv=%b fl=%b h=%b err=%b cnt=%0d, need all 0",
               pc, fetch_valid, flush, halted, misalign_err, fetch_count);
    end
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
    step();
    checks++;
    if ((pc !== 8'd0) || (fetch_valid !== 1'b0) || (halted !== 1'b0)) begin
      failures++;
      $display("FAIL post_rst_idle: pc=%0d fv=%b h=%b, need 0 0 0", pc, fetch_valid, halted);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start = 1'b0;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 8'd0;
    fetch_ready = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_last_pc();
    test_halt_vs_redirect();
    test_rst_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
